alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M MUL, DIV, DIVU, REM and REMU.
- Owns no adder or comparator. It borrows the shared 32-bit ALU for every arithmetic step and drives the ALU's operation, operand_a and operand_b inputs.
- Sits beside the execute stage. The top level grants it the ALU while alu_req is high.
- Fixed latency per op class, so the pipeline can stall deterministically.

---
 rtl/alu_muldiv_seq_pkg.sv | 36 +++
 rtl/alu_muldiv_seq_if.sv | 36 +++
 rtl/alu_muldiv_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq_pkg
// Description : Shared constants for the RV32M multiply/divide sequencer:
//               ALU operation codes, M-extension funct3 codes, helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_muldiv_seq_pkg;

  localparam int          XLEN = 32;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  // Shared ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  // M-extension funct3 codes handled by the sequencer
  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM  = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;

  // MUL and the four divide/remainder codes are implemented; 001/010/011 are not
  function automatic logic md_supported(input logic [2:0] op);
    return (op == MD_MUL) || op[2];
  endfunction

  // Signed divide-class ops need operand and result sign fix-up
  function automatic logic md_signed(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq_if
// Description : Request/result bus and borrowed-ALU bus of the multiply/divide
//               sequencer. slave = sequencer side, master = pipeline/ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_seq_if;
  import alu_muldiv_seq_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            alu_req;
  logic [3:0]      alu_operation;
  logic [XLEN-1:0] alu_operand_a;
  logic [XLEN-1:0] alu_operand_b;
  logic [XLEN-1:0] alu_result;

  modport slave (
    input  start, op, rs1, rs2, flush, alu_result,
    output busy, done, result, alu_req, alu_operation, alu_operand_a, alu_operand_b
  );

  modport master (
    output start, op, rs1, rs2, flush, alu_result,
    input  busy, done, result, alu_req, alu_operation, alu_operand_a, alu_operand_b
  );

endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Fixed-latency RV32M MUL/DIV/DIVU/REM/REMU sequencer. Owns no
//               adder or comparator; every arithmetic step is issued to the
//               shared ALU while alu_req is high.
//               Latency (start edge N): MUL done at N+33, divide class at
//               N+68, unsupported funct3 at N+1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave bus
);

  // The step sequence and counter are built for a 32-bit datapath only
  if (WIDTH != XLEN) begin : g_width_check
    $error("alu_muldiv_seq: only WIDTH=32 is supported");
  end

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NEG_A    = 3'd1,
    ST_NEG_B    = 3'd2,
    ST_MUL_STEP = 3'd3,
    ST_DIV_CMP  = 3'd4,
    ST_DIV_SUB  = 3'd5,
    ST_NEG_R    = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;        // multiplicand (MUL) / |dividend| shifted out MSB-first (div)
  logic [XLEN-1:0] r_b;        // multiplier (MUL) / |divisor| (div)
  logic [XLEN-1:0] r_rem;      // product accumulator (MUL) / partial remainder (div)
  logic [XLEN-1:0] r_quo;
  logic            r_lt;
  logic [4:0]      r_cnt;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_b_zero;
  logic [XLEN-1:0] r_result;

  logic [3:0]      w_alu_op;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_rem_sh;
  logic [XLEN-1:0] w_final_x;
  logic            w_signed_op;
  logic            w_apply_neg;
  logic            w_abort;
  logic            w_last;

  // Remainder with the next dividend bit shifted in, used by the compare step
  assign w_rem_sh    = {r_rem[XLEN-2:0], r_a[XLEN-1]};
  // REM/REMU (funct3 bit 1 set) return the remainder, DIV/DIVU the quotient
  assign w_final_x   = r_op[1] ? r_rem : r_quo;
  assign w_signed_op = md_signed(r_op);
  // Quotient sign fix is skipped for x/0 so the all-ones quotient survives
  assign w_apply_neg = (r_op == MD_DIV) ? ((r_sign_a ^ r_sign_b) & ~r_b_zero) :
                       (r_op == MD_REM) ? r_sign_a : 1'b0;
  assign w_abort     = bus.flush && (r_state != ST_IDLE);
  assign w_last      = (r_cnt == 5'd31);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and ALU drive; flush overrides any transition while busy
  always_comb begin
    w_next_state = r_state;
    w_alu_op     = ALU_ADD;
    w_opa        = ZERO;
    w_opb        = ZERO;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (!md_supported(bus.op)) begin
            w_next_state = ST_DONE;
          end else if (bus.op == MD_MUL) begin
            w_next_state = ST_MUL_STEP;
          end else begin
            w_next_state = ST_NEG_A;
          end
        end
      end
      ST_NEG_A: begin
        w_alu_op     = ALU_SUB;
        w_opb        = r_a;
        w_next_state = ST_NEG_B;
      end
      ST_NEG_B: begin
        w_alu_op     = ALU_SUB;
        w_opb        = r_b;
        w_next_state = ST_DIV_CMP;
      end
      ST_MUL_STEP: begin
        w_alu_op = ALU_ADD;
        w_opa    = r_rem;
        w_opb    = r_a;
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DIV_CMP: begin
        w_alu_op     = ALU_SLTU;
        w_opa        = w_rem_sh;
        w_opb        = r_b;
        w_next_state = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        w_alu_op     = ALU_SUB;
        w_opa        = r_rem;
        w_opb        = r_b;
        w_next_state = w_last ? ST_NEG_R : ST_DIV_CMP;
      end
      ST_NEG_R: begin
        w_alu_op     = ALU_SUB;
        w_opb        = w_final_x;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next_state = ST_IDLE;
    end
  end

  // Datapath: operand latch, shift/accumulate steps and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 3'b000;
      r_a      <= ZERO;
      r_b      <= ZERO;
      r_rem    <= ZERO;
      r_quo    <= ZERO;
      r_lt     <= 1'b0;
      r_cnt    <= 5'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_result <= ZERO;
    end else if (!w_abort) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_a      <= bus.rs1;
            r_b      <= bus.rs2;
            r_rem    <= ZERO;
            r_quo    <= ZERO;
            r_lt     <= 1'b0;
            r_cnt    <= 5'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            if (!md_supported(bus.op)) begin
              r_result <= ZERO;
            end
          end
        end
        ST_MUL_STEP: begin
          if (r_b[0]) begin
            r_rem <= bus.alu_result;
          end
          r_a   <= {r_a[XLEN-2:0], 1'b0};
          r_b   <= {1'b0, r_b[XLEN-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result <= r_b[0] ? bus.alu_result : r_rem;
          end
        end
        ST_NEG_A: begin
          if (w_signed_op && r_a[XLEN-1]) begin
            r_a <= bus.alu_result;
          end
          r_sign_a <= w_signed_op && r_a[XLEN-1];
        end
        ST_NEG_B: begin
          if (w_signed_op && r_b[XLEN-1]) begin
            r_b <= bus.alu_result;
          end
          r_sign_b <= w_signed_op && r_b[XLEN-1];
          r_b_zero <= (r_b == ZERO);
        end
        ST_DIV_CMP: begin
          r_rem <= w_rem_sh;
          r_a   <= {r_a[XLEN-2:0], 1'b0};
          r_lt  <= bus.alu_result[0];
        end
        ST_DIV_SUB: begin
          if (!r_lt) begin
            r_rem <= bus.alu_result;
          end
          r_quo <= {r_quo[XLEN-2:0], ~r_lt};
          r_cnt <= r_cnt + 5'd1;
        end
        ST_NEG_R: begin
          r_result <= w_apply_neg ? bus.alu_result : w_final_x;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.alu_req       = (r_state != ST_IDLE);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.result        = r_result;
  assign bus.alu_operation = w_alu_op;
  assign bus.alu_operand_a = w_opa;
  assign bus.alu_operand_b = w_opb;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq with a behavioural ALU
//               and an arithmetic reference model of RV32M results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU as seen by the sequencer
  function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLTU: return {31'd0, (a < b)};
      default:  return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b);

  // RV32M result rules computed with wide signed arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MUL:  begin q = sa * sb; return q[31:0]; end
      MD_DIV:  begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      MD_DIVU: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      MD_REM:  begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      MD_REMU: begin if (b == 0) return a; return a % b; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    if (op == MD_MUL) return 33;
    if (op[2]) return 68;
    return 1;
  endfunction

  // Issue one op and follow it to done (bounded); reports observations
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output bit busy_ok, output bit add_ok, output bit idle_ok);
    busy_ok = 1'b1;
    add_ok  = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy !== 1'b1 || bus.alu_req !== 1'b1) busy_ok = 1'b0;
      if (op == MD_MUL && bus.alu_operation !== ALU_ADD) add_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    res = bus.result;
    @(posedge clk); #1;
    idle_ok = (bus.busy === 1'b0) && (bus.done === 1'b0) && (bus.alu_operation === ALU_ADD) &&
              (bus.alu_operand_a === 32'd0) && (bus.alu_operand_b === 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.alu_req !== 1'b0) begin n_err++; $display("FAIL reset_alu_req got=%b want=0", bus.alu_req); end
    n_cmp++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", bus.result); end
    n_cmp++; if (bus.alu_operation !== ALU_ADD || bus.alu_operand_a !== 32'd0 || bus.alu_operand_b !== 32'd0) begin
      n_err++; $display("FAIL reset_alu_drive got=%h/%h/%h want=%h/0/0", bus.alu_operation, bus.alu_operand_a, bus.alu_operand_b, ALU_ADD);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; bit bok, aok, iok;
    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bok, aok, iok);
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got=%h want=ffffffeb", res); end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL mul_latency got=%0d want=33", lat); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL mul_busy got=low want=high through N+33"); end
    n_cmp++; if (!aok) begin n_err++; $display("FAIL mul_alu_op got=non-ADD want=ADD in MUL_STEP"); end
    n_cmp++; if (!iok) begin n_err++; $display("FAIL mul_return_idle got=not idle want=idle after done"); end
  endtask

  task automatic test_div_directed();
    logic [2:0]  ops [10] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_DIVU, MD_REM, MD_DIV, MD_REMU, MD_DIV, MD_REM};
    logic [31:0] as  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd9,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd9,
                              32'h8000_0000, 32'd0};
    logic [31:0] res; int lat; bit bok, aok, iok;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bok, aok, iok);
      n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL div_dir[%0d] op=%b a=%h b=%h got=%h want=%h", i, ops[i], as[i], bs[i], res, exp[i]); end
      n_cmp++; if (lat != 68) begin n_err++; $display("FAIL div_dir_lat[%0d] got=%0d want=68", i, lat); end
      n_cmp++; if (!bok) begin n_err++; $display("FAIL div_dir_busy[%0d] got=low want=high", i); end
    end
  endtask

  task automatic test_random();
    logic [2:0] oplist [5] = '{MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    logic [2:0] op; logic [31:0] a, b, res; int lat; bit bok, aok, iok;
    for (int i = 0; i < 40; i++) begin
      op = oplist[$urandom_range(0, 4)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = $urandom_range(0, 255); b = 32'hFFFF_FFFF - $urandom_range(0, 3); end
        3: a = 32'h8000_0000 | $urandom_range(0, 3);
        default: ;
      endcase
      run_op(op, a, b, res, lat, bok, aok, iok);
      n_cmp++; if (res !== ref_md(op, a, b)) begin n_err++; $display("FAIL rand[%0d] op=%b a=%h b=%h got=%h want=%h", i, op, a, b, res, ref_md(op, a, b)); end
      n_cmp++; if (lat != ref_lat(op)) begin n_err++; $display("FAIL rand_lat[%0d] op=%b got=%0d want=%0d", i, op, lat, ref_lat(op)); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, prior; int lat; bit bok, aok, iok, saw_done;
    prior = 32'h1234_5678;
    run_op(MD_MUL, prior, 32'd1, res, lat, bok, aok, iok);
    // flush in IDLE must not disturb anything
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.result !== prior) begin n_err++; $display("FAIL flush_idle got busy=%b res=%h want busy=0 res=%h", bus.busy, bus.result, prior); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIV; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    // cycle N+10: flush together with a start that must lose
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = MD_MUL;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL flush_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.result !== prior) begin n_err++; $display("FAIL flush_result got=%h want=%h", bus.result, prior); end
    saw_done = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1; end
    n_cmp++; if (saw_done) begin n_err++; $display("FAIL flush_quiet got=activity want=idle after flush"); end
  endtask

  task automatic test_start_while_busy();
    int lat; logic [31:0] a, b, exp;
    a = $urandom; b = $urandom; exp = ref_md(MD_MUL, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MUL; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.op = MD_DIVU; bus.rs1 = 32'd77; bus.rs2 = 32'd5;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL busy_start_lat got=%0d want=33", lat); end
    n_cmp++; if (bus.result !== exp) begin n_err++; $display("FAIL busy_start_result got=%h want=%h", bus.result, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIV; bus.rs1 = 32'hFFFF_0000; bus.rs2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.alu_req !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b/%b want=0/0", bus.busy, bus.alu_req); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    n_cmp++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL midrst_result got=%h want=0", bus.result); end
  endtask

  task automatic test_unsupported();
    logic [2:0] bad [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] res; int lat; bit bok, aok, iok;
    for (int i = 0; i < 3; i++) begin
      run_op(MD_MUL, 32'd9, 32'd11, res, lat, bok, aok, iok);
      run_op(bad[i], 32'hDEAD_BEEF, 32'd3, res, lat, bok, aok, iok);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL unsup_lat[%0d] got=%0d want=1", i, lat); end
      n_cmp++; if (res !== 32'd0) begin n_err++; $display("FAIL unsup_result[%0d] got=%h want=0", i, res); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    bus.flush = 1'b0;
    test_reset();
    test_mul();
    test_div_directed();
    test_random();
    test_flush();
    test_start_while_busy();
    test_midop_reset();
    test_unsupported();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
